hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Pipeline control block that drives the enable and flush inputs of the pipeline registers: PC write, IF/ID write-enable, IF/ID flush and the ID/EX bubble.
- Resolves four conditions:
  - load-use data hazards
  - taken-branch flushes
  - instruction-memory fetch waits
  - a fixed-latency multi-cycle multiply that holds EX
- Also keeps a saturating stall-cycle performance counter.
- Sits beside the ID stage; all hazard outputs are same-cycle combinational from registered state plus inputs.

Parameters:
- REG_W, 5, register-specifier width.
- MUL_LAT, 4, total EX-occupancy cycles of a multiply, including the start cycle. Legal range 1..8.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  REG_W  rs field of the ID instruction.
- id_rt  in  REG_W  rt field of the ID instruction.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rt  in  REG_W  destination of the EX load.
- id_branch_taken  in  1  branch resolved taken in ID.
- ex_mul_start  in  1  multiply enters EX this cycle.
- imem_ready  in  1  instruction memory has valid data this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID write enable.
- if_id_flush  out  1  clears IF/ID at the next edge.
- id_ex_bubble  out  1  zeroes ID/EX control at the next edge.
- ex_hold  out  1  holds ID/EX and the EX unit.
- stall_cycles  out  CNT_W  count of cycles with pc_write=0.

Behaviour:
- State register: RUN, MUL_WAIT. Down-counter mul_cnt is 3 bits.
- Reset (rst=1 at an edge): state<=RUN, mul_cnt<=0, stall_cycles<=0.
- Outputs while rst=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_hold=0.
- Default (RUN, no condition): pc_write=1, if_id_write=1, flush=0, bubble=0, ex_hold=0.
- Load-use term: lu = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Priority, highest first, evaluated in RUN:
  1. ex_mul_start with MUL_LAT>1:
     - Outputs: pc_write=0, if_id_write=0, ex_hold=1, bubble=0, flush=0.
     - Next state MUL_WAIT with mul_cnt<=MUL_LAT-2.
     - With MUL_LAT=1 this term is ignored.
  2. lu:
     - Outputs: pc_write=0, if_id_write=0, bubble=1, flush=0.
     - id_branch_taken is ignored this cycle; it re-evaluates next cycle.
     - Lasts exactly one cycle per load.
  3. id_branch_taken:
     - Outputs: pc_write=1, if_id_write=1, flush=1.
     - Applies regardless of imem_ready; the pending fetch is abandoned.
  4. !imem_ready:
     - Outputs: pc_write=0, if_id_write=1, flush=1.
     - The ID instruction proceeds and a NOP enters IF/ID.
- MUL_WAIT:
  - Outputs: pc_write=0, if_id_write=0, ex_hold=1, bubble=0, flush=0.
  - All other inputs are ignored.
  - If mul_cnt==0: next state RUN. Otherwise mul_cnt decrements.
  - ex_hold is therefore high for exactly MUL_LAT consecutive cycles, counting the start cycle.
- stall_cycles:
  - Increments at each edge where rst=0 and pc_write=0.
  - Saturates at 2^CNT_W-1 and never wraps.
- Reset mid-MUL_WAIT: returns to RUN next cycle; ex_hold drops immediately while rst=1.
- No X propagation: every output is fully assigned in every state.

Decomposition:
- Package hazard_pkg:
  - state enum {RUN, MUL_WAIT}
  - constant REG_ZERO
  - MUL_LAT bounds check constants
- Sub-module sat_counter (parameter W; ports clk, rst, inc, q). Instantiated once for stall_cycles.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs -> pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_hold=0, stall_cycles=0.
- Load-use:
  - ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly 1 cycle; stall_cycles=1.
  - Same with ex_rt=0 -> no stall.
- Branch plus fetch wait: id_branch_taken=1, imem_ready=0 -> pc_write=1, if_id_flush=1. Next cycle, branch=0, imem_ready=0 -> pc_write=0, if_id_write=1, if_id_flush=1.
- Multiply, MUL_LAT=4:
  - Pulse ex_mul_start -> ex_hold=1 for 4 consecutive cycles; pc_write=0 throughout; stall_cycles=4.
  - A lu condition applied in cycle 2 has no effect.
- Reset mid-multiply: assert rst in cycle 2 of MUL_WAIT -> after release, state is RUN, ex_hold=0, stall_cycles=0.
- Saturation: with CNT_W=4, hold imem_ready=0 for 20 cycles -> stall_cycles reaches 15 and stays at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// ============================================================================
// hazard_pkg : shared types and constants for the hazard/stall controller
// Revision   : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  localparam int REG_ZERO    = 0;
  localparam int MUL_CNT_W   = 3;
  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 8;

endpackage

`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
// ============================================================================
// hazard_stall_ctrl_if : ID-stage hazard inputs and pipeline-register controls
// Revision             : 1.0
// ============================================================================
`default_nettype none

interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             id_branch_taken;
  logic             ex_mul_start;
  logic             imem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_hold;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side: reports hazard sources, consumes enables.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           id_branch_taken, ex_mul_start, imem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
           ex_hold, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           id_branch_taken, ex_mul_start, imem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
           ex_hold, stall_cycles
  );

endinterface

`default_nettype wire

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// ============================================================================
// sat_counter : up-counter that sticks at all-ones instead of wrapping
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         inc,
  output logic      [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// hazard_stall_ctrl : load-use / branch / fetch-wait / multiply stall control
// Revision          : 1.0
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  hazard_stall_ctrl_if.slave     bus
);

  localparam bit                 MUL_EN     = (MUL_LAT > 1);
  localparam logic [MUL_CNT_W-1:0] MUL_RELOAD =
    (MUL_LAT > 1) ? MUL_CNT_W'(MUL_LAT - 2) : '0;

  if ((MUL_LAT < MUL_LAT_MIN) || (MUL_LAT > MUL_LAT_MAX)) begin : g_bad_mul_lat
    $error("hazard_stall_ctrl: MUL_LAT out of range");
  end

  state_e               state_q, state_d;
  logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;

  logic w_load_use;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_bubble;
  logic w_ex_hold;

  assign w_load_use = bus.ex_mem_read
                    && (bus.ex_rt != REG_W'(REG_ZERO))
                    && ((bus.ex_rt == bus.id_rs)
                        || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  always_comb begin
    state_d        = state_q;
    mul_cnt_d      = mul_cnt_q;
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_bubble = 1'b0;
    w_ex_hold      = 1'b0;

    case (state_q)
      RUN: begin
        if (MUL_EN && bus.ex_mul_start) begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_ex_hold     = 1'b1;
          state_d       = MUL_WAIT;
          mul_cnt_d     = MUL_RELOAD;
        end else if (w_load_use) begin
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_id_ex_bubble = 1'b1;
        end else if (bus.id_branch_taken) begin
          w_if_id_flush = 1'b1;
        end else if (!bus.imem_ready) begin
          // ID instruction moves on; a NOP fills IF/ID while fetch waits.
          w_pc_write    = 1'b0;
          w_if_id_flush = 1'b1;
        end
      end
      MUL_WAIT: begin
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_ex_hold     = 1'b1;
        if (mul_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          mul_cnt_d = mul_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Reset takes over the outputs immediately, not at the next edge.
    if (rst) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_if_id_flush  = 1'b1;
      w_id_ex_bubble = 1'b1;
      w_ex_hold      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!w_pc_write),
    .q   (bus.stall_cycles)
  );

  assign bus.pc_write     = w_pc_write;
  assign bus.if_id_write  = w_if_id_write;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_bubble = w_id_ex_bubble;
  assign bus.ex_hold      = w_ex_hold;

endmodule

`default_nettype wire
